// File: rtl/dffram_2p.sv
// Two-port register-file RAM: port 0 read/write with byte enables, port 1 read-only, zero-filled after reset.
// Define DFFRAM_BYPASS_EN to forward port 0 write data to a same-address port 1 read in the same cycle.
module dffram_2p #(
  parameter int WORDS = 256,
  parameter int WSIZE = 4,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN0,
  input  logic [WSIZE-1:0]     WE0,
  input  logic [AW-1:0]        A0,
  input  logic [8*WSIZE-1:0]   Di0,
  output logic [8*WSIZE-1:0]   Do0,
  input  logic                 EN1,
  input  logic [AW-1:0]        A1,
  output logic [8*WSIZE-1:0]   Do1,
  output logic                 BUSY,
  output logic                 o_dbg_state
);

  localparam int DW = 8 * WSIZE;
  localparam logic [AW:0]   LP_WORDS = (AW+1)'(WORDS);
  localparam logic [AW-1:0] LP_LAST  = AW'(WORDS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_cnt;
  logic [DW-1:0]   r_mem [0:WORDS-1];
  logic [DW-1:0]   r_do0;
  logic [DW-1:0]   r_do1;

  logic            w_busy;
  logic            w_ready;
  logic            w_a0_ok;
  logic            w_a1_ok;
  logic            w_rd0;
  logic            w_wr0;
  logic            w_rd1;
  logic [DW-1:0]   w_old0;
  logic [DW-1:0]   w_old1;
  logic [DW-1:0]   w_rd1_data;
`ifdef DFFRAM_BYPASS_EN
  logic            w_coll;
  logic [DW-1:0]   w_merged;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave CLEAR once the last word has been zeroed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_cnt == LP_LAST) w_state_nxt = ST_READY;
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // State-derived outputs
  always_comb begin
    w_busy  = (r_state == ST_CLEAR);
    w_ready = (r_state == ST_READY);
  end

  assign BUSY        = w_busy;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (w_busy) begin
      r_cnt <= r_cnt + AW'(1);
    end
  end

  // Access decode; a cycle with RST high never performs an access
  assign w_a0_ok = ({1'b0, A0} < LP_WORDS);
  assign w_a1_ok = ({1'b0, A1} < LP_WORDS);
  assign w_rd0   = w_ready && !RST && EN0 && (WE0 == '0);
  assign w_wr0   = w_ready && !RST && EN0 && (WE0 != '0) && w_a0_ok;
  assign w_rd1   = w_ready && !RST && EN1;
  assign w_old0  = w_a0_ok ? r_mem[A0] : '0;
  assign w_old1  = w_a1_ok ? r_mem[A1] : '0;

  always_comb begin
`ifdef DFFRAM_BYPASS_EN
    w_coll   = w_wr0 && (A0 == A1);
    w_merged = w_old1;
    for (int i = 0; i < WSIZE; i++) begin
      if (WE0[i]) w_merged[8*i +: 8] = Di0[8*i +: 8];
    end
    w_rd1_data = w_coll ? w_merged : w_old1;
`else
    w_rd1_data = w_old1;
`endif
  end

  // Storage: zero fill while busy, byte-masked port 0 writes when ready
  always_ff @(posedge CLK) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr0) begin
      for (int i = 0; i < WSIZE; i++) begin
        if (WE0[i]) r_mem[A0][8*i +: 8] <= Di0[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_do0 <= '0;
      r_do1 <= '0;
    end else begin
      if (w_rd0) r_do0 <= w_old0;
      if (w_rd1) r_do1 <= w_rd1_data;
    end
  end

  assign Do0 = r_do0;
  assign Do1 = r_do1;

endmodule

// File: tb/tb_dffram_2p.sv
// Self-checking bench for dffram_2p: a 256-word and a 200-word instance share one stimulus stream
// and are compared every cycle against an array-based model, plus directed vectors and corner sequences.
module tb_dffram_2p;

`ifdef DFFRAM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam logic [31:0] COLL_EXP = BYPASS ? 32'hAABB3344 : 32'h11223344;

  // clock / reset block
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, EN0, EN1;
  logic [3:0]  WE0;
  logic [7:0]  A0, A1;
  logic [31:0] Di0;
  logic [31:0] do0_a, do1_a, do0_b, do1_b;
  logic        busy_a, busy_b, dbg_a, dbg_b;

  dffram_2p #(.WORDS(256), .WSIZE(4)) u_ram256 (
    .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(do0_a),
    .EN1(EN1), .A1(A1), .Do1(do1_a), .BUSY(busy_a), .o_dbg_state(dbg_a)
  );

  dffram_2p #(.WORDS(200), .WSIZE(4)) u_ram200 (
    .CLK(CLK), .RST(RST), .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(do0_b),
    .EN1(EN1), .A1(A1), .Do1(do1_b), .BUSY(busy_b), .o_dbg_state(dbg_b)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference model: whole array zeroed on reset, busy for WORDS edges after deassertion
  logic [31:0] m_mem [2][256];
  bit          m_ready [2];
  int          m_cnt [2];
  logic [31:0] m_do0 [2];
  logic [31:0] m_do1 [2];

  function automatic int words_of(int k);
    return (k == 0) ? 256 : 200;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] we);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (we[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int  w;
      bit  ok0, ok1, wr;
      w = words_of(k);
      if (RST) begin
        m_ready[k] = 1'b0;
        m_cnt[k]   = 0;
        m_do0[k]   = '0;
        m_do1[k]   = '0;
        for (int a = 0; a < 256; a++) m_mem[k][a] = '0;
      end else if (!m_ready[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == w) m_ready[k] = 1'b1;
      end else begin
        ok0 = (int'(A0) < w);
        ok1 = (int'(A1) < w);
        wr  = EN0 && (WE0 != 4'h0) && ok0;
        if (EN0 && WE0 == 4'h0) m_do0[k] = ok0 ? m_mem[k][A0] : 32'h0;
        if (EN1) begin
          if (!ok1) m_do1[k] = 32'h0;
          else if (wr && A0 == A1 && BYPASS) m_do1[k] = merge(m_mem[k][A1], Di0, WE0);
          else m_do1[k] = m_mem[k][A1];
        end
        if (wr) m_mem[k][A0] = merge(m_mem[k][A0], Di0, WE0);
      end
    end
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one clock edge, update model, check all outputs away from the edge
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("do0_256",   do0_a,  m_do0[0]);
    chk("do1_256",   do1_a,  m_do1[0]);
    chk("busy_256",  {31'b0, busy_a}, {31'b0, !m_ready[0]});
    chk("state_256", {31'b0, dbg_a},  {31'b0, m_ready[0]});
    chk("do0_200",   do0_b,  m_do0[1]);
    chk("do1_200",   do1_b,  m_do1[1]);
    chk("busy_200",  {31'b0, busy_b}, {31'b0, !m_ready[1]});
  endtask

  task automatic set_idle();
    EN0 = 1'b0; WE0 = 4'h0; A0 = 8'h0; Di0 = 32'h0; EN1 = 1'b0; A1 = 8'h0;
  endtask

  // one-cycle reset pulse, then count edges until each BUSY drops
  task automatic do_reset(input bit hammer);
    int n, na, nb;
    logic [31:0] seen0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    if (hammer) begin
      EN0 = 1'b1; WE0 = 4'hF; A0 = 8'd3; Di0 = 32'hFFFFFFFF; EN1 = 1'b1; A1 = 8'd3;
    end
    n = 0; na = -1; nb = -1; seen0 = '0;
    while ((na < 0 || nb < 0) && n < 1000) begin
      step();
      n++;
      seen0 |= do0_a;
      if (na < 0 && !busy_a) na = n;
      if (nb < 0 && !busy_b) nb = n;
    end
    chk("fill_len_256", na, 256);
    chk("fill_len_200", nb, 200);
    if (hammer) chk("busy_do0_held", seen0, 32'h0);
    set_idle();
  endtask

  typedef struct {
    bit          en0;
    logic [3:0]  we0;
    logic [7:0]  a0;
    logic [31:0] di0;
    bit          en1;
    logic [7:0]  a1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 8'h00, 32'h00000000, 32'h00000000};
    vecs[1] = '{1'b1, 4'h1, 8'h10, 32'h000000AA, 1'b0, 8'h00, 32'h00000000, 32'h00000000};
    vecs[2] = '{1'b1, 4'h0, 8'h10, 32'h00000000, 1'b0, 8'h00, 32'hDEADBEAA, 32'h00000000};
    vecs[3] = '{1'b1, 4'hF, 8'h05, 32'h11223344, 1'b1, 8'h10, 32'hDEADBEAA, 32'hDEADBEAA};
    vecs[4] = '{1'b1, 4'hC, 8'h05, 32'hAABBCCDD, 1'b1, 8'h05, 32'hDEADBEAA, COLL_EXP};
    vecs[5] = '{1'b1, 4'h0, 8'h05, 32'h00000000, 1'b1, 8'h05, 32'hAABB3344, 32'hAABB3344};
    vecs[6] = '{1'b0, 4'h0, 8'h05, 32'h00000000, 1'b0, 8'h00, 32'hAABB3344, 32'hAABB3344};
    vecs[7] = '{1'b1, 4'h3, 8'h05, 32'h12345678, 1'b1, 8'h10, 32'hAABB3344, 32'hDEADBEAA};
    vecs[8] = '{1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h05, 32'hAABB3344, 32'hAABB5678};

    for (int k = 0; k < 2; k++) begin
      m_ready[k] = 1'b0; m_cnt[k] = 0; m_do0[k] = '0; m_do1[k] = '0;
    end
    RST = 1'b1;
    set_idle();

    // reset fill with accesses hammered at word 3 during the fill
    do_reset(1'b1);
    EN0 = 1'b1; A0 = 8'd3;
    step();
    chk("busy_blk_mem3", do0_a, 32'h0);
    set_idle();

    for (int a = 0; a < 256; a++) begin
      EN1 = 1'b1; A1 = 8'(a);
      step();
      chk("fill_zero_256", do1_a, 32'h0);
    end
    set_idle();

    // directed vectors
    for (int i = 0; i < 9; i++) begin
      vec_t v;
      v = vecs[i];
      EN0 = v.en0; WE0 = v.we0; A0 = v.a0; Di0 = v.di0; EN1 = v.en1; A1 = v.a1;
      step();
      chk($sformatf("vec%0d_do0", i), do0_a, v.exp0);
      chk($sformatf("vec%0d_do1", i), do1_a, v.exp1);
    end
    set_idle();

    // out-of-range on the 200-word instance
    EN0 = 1'b1; WE0 = 4'hF; A0 = 8'd250; Di0 = 32'hFFFFFFFF;
    step();
    set_idle();
    EN1 = 1'b1; A1 = 8'd250; EN0 = 1'b1; A0 = 8'd250;
    step();
    chk("oor_rd1_200", do1_b, 32'h0);
    chk("oor_rd0_200", do0_b, 32'h0);
    chk("inrange_rd1_256", do1_a, 32'hFFFFFFFF);
    EN0 = 1'b0; A1 = 8'd199;
    step();
    chk("oor_mem199_200", do1_b, 32'h0);
    A1 = 8'd0;
    step();
    chk("oor_mem0_200", do1_b, 32'h0);
    set_idle();

    // mid-fill reset at counter 100
    RST = 1'b1;
    step();
    RST = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("midfill_busy", {31'b0, busy_a}, 32'h1);
    do_reset(1'b0);

    // randomized traffic, mostly a small address window to provoke collisions
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 1499) == 0);
      EN0 = $urandom_range(0, 3) != 0;
      WE0 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      A0  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
      Di0 = $urandom;
      EN1 = $urandom_range(0, 3) != 0;
      A1  = ($urandom_range(0, 3) == 0) ? A0 :
            (($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15)));
      step();
    end
    RST = 1'b0;
    set_idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dffram_2p.md
# dffram_2p

Parametrised two-port DFF/latch-free register-file RAM, successor to the fixed 256x32 single-port macro. Port 0 is read/write with byte enables; port 1 is read-only. Both ports have registered, synchronous reads. After reset the block sequentially zero-fills the whole array and reports `BUSY` until the fill is complete. It sits beside the CPU and DMA masters as general-purpose SRAM replacement.

## Interface

**Parameters**
- `WORDS`, default 256: number of words; any value ≥ 2, need not be a power of two.
- `WSIZE`, default 4: bytes per word; data width is 8·`WSIZE`.
- `AW`, default $clog2(`WORDS`): address width (derived; do not override).

**Ports**
- `CLK`  in  1: single clock; all state updates on rising edge.
- `RST`  in  1: synchronous, active-high reset.
- `EN0`  in  1: port 0 access enable.
- `WE0`  in  `WSIZE`: port 0 byte write enables; bit i covers `Di0[8i+7:8i]`.
- `A0`  in  `AW`: port 0 word address.
- `Di0`  in  8·`WSIZE`: port 0 write data.
- `Do0`  out  8·`WSIZE`: port 0 registered read data.
- `EN1`  in  1: port 1 read enable.
- `A1`  in  `AW`: port 1 word address.
- `Do1`  out  8·`WSIZE`: port 1 registered read data.
- `BUSY`  out  1: high during reset and zero-fill; all port accesses are ignored while high.

## Operation

- **FSM states:** `CLEAR`, `READY`.
- `RST`=1 → state `CLEAR`, fill counter = 0, `Do0`=0, `Do1`=0, `BUSY`=1.
- **`CLEAR`:** each cycle writes all-zero to `mem[counter]` and increments the counter. When counter = `WORDS`-1 and that word is written, go to `READY` and set `BUSY`=0 on the next edge. `EN0`/`EN1` are ignored; `Do0`/`Do1` hold 0.
- **`READY`, port 0:**
  - `EN0`=1, `WE0`=0: `Do0` ← `mem[A0]`.
  - `EN0`=1, `WE0`≠0: for each set bit i, `mem[A0]` byte i ← `Di0` byte i. `Do0` holds (no read-modify-write output).
  - `EN0`=0: no change; `Do0` holds.
- **`READY`, port 1:** `EN1`=1 → `Do1` ← `mem[A1]`; `EN1`=0 → `Do1` holds.
- **Out-of-range address** (≥ `WORDS`): writes are dropped; reads load 0 into the output register.
- **Same-cycle collision** (port 0 write and port 1 read to the same address): behaviour is set by `DFFRAM_BYPASS_EN` (see Configuration).
- **Port 0 read and port 1 read to the same address:** both return the stored word.
- **`RST` asserted mid-fill or during `READY`:** restarts the fill from word 0. Previous contents are not preserved.

## Timing

- Read latency is 1 cycle: address and enable sampled at edge N, data valid after edge N, held until the next enabled read.
- Write is visible to any read issued on the cycle after the write edge.
- `BUSY` is 1 from the reset edge through exactly `WORDS` cycles after `RST` deasserts. The first accepted access is in cycle `WORDS`+1 after deassertion.
- No combinational path from inputs to `Do0`, `Do1` or `BUSY`.

## Configuration

- **`DFFRAM_BYPASS_EN` defined:** on a collision, `Do1` gets the merged word: written bytes come from `Di0`, unwritten bytes from the old `mem` contents. This adds a forwarding mux on the port 1 read path.
- **`DFFRAM_BYPASS_EN` undefined:** on a collision, `Do1` gets the old (pre-write) contents. No forwarding logic is built.
- In both cases the array holds the new data after the edge.

## Test plan

- **Reset fill:** `WORDS`=256, pulse `RST` 1 cycle. `BUSY`=1 for exactly 256 cycles after deassertion, then 0. Reading all addresses on port 1 returns 0x00000000.
- **Byte write:** write 0xDEADBEEF to A0=0x10 with `WE0`=4'hF, then 0x000000AA with `WE0`=4'b0001. Port 0 read of 0x10 returns 0xDEADBEAA one cycle after the read edge.
- **Collision:** `mem[5]`=0x11223344; port 0 writes 0xAABBCCDD with `WE0`=4'b1100 while port 1 reads A1=5.
  - With `DFFRAM_BYPASS_EN`: `Do1`=0xAABB3344.
  - Without: `Do1`=0x11223344.
  - Both builds: the next read returns 0xAABB3344.
- **Busy blocking:** during the fill, drive `EN0`=1, `WE0`=4'hF, A0=3, `Di0`=0xFFFFFFFF. After the fill, `mem[3]`=0 and `Do0` stayed 0 throughout.
- **Out of range:** `WORDS`=200. Write to A0=250, then read A1=250 → `Do1`=0; `mem[199]` and `mem[0]` are unchanged.
- **Mid-fill reset:** assert `RST` at fill counter 100. `BUSY` stays high for a full 256 cycles after the second deassertion.
